tc_fsm_mc: RTL
==============

# tc_fsm_mc

Multi-channel task controller between the signal network, the memory request arbiter (MRA), one prefetch (PF) core and `NUM_SIMD` SIMD cores. For each work list announced by the signal network, it:
- fetches one descriptor line per entry,
- runs the PF core on that entry,
- dispatches the entry to the lowest-index idle SIMD channel.

It signals completion after the last channel drains. It is the multi-channel successor of the single-SIMD task controller and sits in the quark tile in its place.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, address/pointer width.
- `DATA_WIDTH`, 512, MRA line width; must be ≥ 4*`ADDR_WIDTH`.
- `WL_LEN_BITS`, 8, work-list length width.
- `NUM_SIMD`, 4, number of SIMD channels (1..16).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `MRA_req_addr` out `ADDR_WIDTH`: line address of the descriptor read.
- `MRA_rw` out 1: 0 = read; constant 0.
- `MRA_req_valid` out 1: request valid.
- `MRA_ready` in 1: arbiter accepts the request.
- `MRA_rsp_data` in `DATA_WIDTH`: response line.
- `MRA_rsp_valid` in 1: response valid.
- `PF_pointer` out `ADDR_WIDTH`: PF program pointer.
- `PF_reset` out 1: 1 holds the PF core in reset; 0 runs it.
- `PF_done` in 1: PF completion.
- `SIMD_pointer` out `NUM_SIMD*ADDR_WIDTH`: per-channel program pointer; channel i occupies bits [i*A +: A].
- `SIMD_g_arg_pointer` out `NUM_SIMD*ADDR_WIDTH`: per-channel global-argument pointer.
- `SIMD_l_arg_pointer` out `NUM_SIMD*ADDR_WIDTH`: per-channel local-argument pointer.
- `SIMD_reset` out `NUM_SIMD`: per-channel reset; 1 = held.
- `SIMD_done` in `NUM_SIMD`: per-channel completion.
- `SN_next_op` in 1: a work list is pending.
- `SN_next_addr` in `ADDR_WIDTH`: work-list base address.
- `SN_next_len` in `WL_LEN_BITS`: number of entries.
- `SN_clr_next` out 1: one-cycle acknowledge of `SN_next_op`.
- `SN_req_done` out 1: one-cycle work-list completion pulse.

## Operation
Descriptor line layout (A = `ADDR_WIDTH`):
- [A-1:0] PF pointer.
- [2A-1:A] SIMD pointer.
- [3A-1:2A] global-argument pointer.
- [4A-1:3A] local-argument pointer.
- Remaining bits ignored.

Entry k is located at `base + k*(DATA_WIDTH/8)`, computed modulo 2^A. The index counter is `WL_LEN_BITS` wide.

State machine:
- IDLE: on `SN_next_op`, latch address and length, pulse `SN_clr_next`. Length 0 → DONE; otherwise → FETCH_REQ.
- FETCH_REQ: drive `MRA_req_valid` with the entry address. On `MRA_ready`, go to FETCH_WAIT.
- FETCH_WAIT: on `MRA_rsp_valid`, latch the descriptor and go to PF_WAIT.
- PF_WAIT: `PF_reset`=0. On `PF_done`, go to DISPATCH.
- DISPATCH: wait for any idle channel. Load the lowest-index idle channel's three pointers, mark it busy, and increment the index. If the index reaches the length → DRAIN; otherwise → FETCH_REQ.
- DRAIN: when all channels are idle, go to DONE.
- DONE: pulse `SN_req_done`, then return to IDLE.

Channel rules:
- A busy channel has `SIMD_reset`=0. `SIMD_done[i]` while busy clears busy, and reset re-asserts the next cycle.
- `SIMD_done` on an idle channel is ignored.
- Pointer outputs hold their last loaded value while the channel is idle.

## Timing
- Reset values: all pointers and `MRA_req_addr` 0; `MRA_req_valid`, `MRA_rw`, `SN_clr_next` and `SN_req_done` 0; `PF_reset` 1; `SIMD_reset` all ones; state IDLE; all channels idle.
- Reset asserted mid-operation aborts the work list immediately. No done pulse is issued.
- Request handshake: valid and address are stable from assertion until the cycle with `MRA_ready`=1. At most one request is outstanding.
- A response arriving outside FETCH_WAIT is ignored.
- `SN_clr_next` is asserted in the cycle after `SN_next_op` is sampled in IDLE. `MRA_req_valid` asserts in the cycle after that.
- `SN_next_op` in any state other than IDLE is not acknowledged.
- `PF_reset` returns to 1 in the cycle after `PF_done` is sampled.
- A channel's `SIMD_reset` deasserts in the cycle after DISPATCH selects it.
- `SIMD_done[i]` in the same cycle as DISPATCH: channel i is not selectable in that cycle; it becomes selectable in the next cycle.
- Single-entry latency, counted from `SN_clr_next` with zero-wait MRA, PF and SIMD: request, response, PF, dispatch, SIMD done, drain, done. Eight cycles minimum.

## Configuration
- Macro: `TC_FSM_MC_PF_BYPASS_EN`.
- Defined: a descriptor whose PF pointer equals 0 skips PF_WAIT and goes from FETCH_WAIT directly to DISPATCH. `PF_reset` stays 1 for that entry.
- Not defined: PF_WAIT runs for every entry, including those with PF pointer 0.

## Test plan
- Length 0, base 0x1000 → `SN_clr_next` pulse, then `SN_req_done` one cycle later. No MRA request is made.
- Length 3, base 0x1000, `NUM_SIMD`=4, SIMDs never done during dispatch → requests at 0x1000, 0x1040 and 0x1080; channels 0, 1 and 2 are loaded. After all three `SIMD_done` pulses, exactly one `SN_req_done`.
- `MRA_ready` held low for 5 cycles → `MRA_req_valid` and the address stay stable for all 5 cycles. The request is accepted on cycle 6.
- Length 5 with all 4 channels busy → the controller stalls in DISPATCH. `SIMD_done[2]` → entry 4 is loaded into channel 2 one cycle later.
- Reset asserted during PF_WAIT → `PF_reset`=1, `SIMD_reset`=all ones, and no `SN_req_done`. The next `SN_next_op` is processed normally.
- Bypass enabled, PF pointer 0 → `PF_reset` never deasserts and dispatch occurs without `PF_done`.

Source files
------------

// File: rtl/tc_fsm_mc.sv
// tc_fsm_mc: multi-channel task controller (descriptor fetch, PF run, dispatch to the lowest idle SIMD).
// Optional build macro TC_FSM_MC_PF_BYPASS_EN: descriptors with a zero PF pointer skip the PF core.
module tc_fsm_mc #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 512,
  parameter int WL_LEN_BITS = 8,
  parameter int NUM_SIMD    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [ADDR_WIDTH-1:0]          MRA_req_addr,
  output logic                           MRA_rw,
  output logic                           MRA_req_valid,
  input  logic                           MRA_ready,
  input  logic [DATA_WIDTH-1:0]          MRA_rsp_data,
  input  logic                           MRA_rsp_valid,
  output logic [ADDR_WIDTH-1:0]          PF_pointer,
  output logic                           PF_reset,
  input  logic                           PF_done,
  output logic [NUM_SIMD*ADDR_WIDTH-1:0] SIMD_pointer,
  output logic [NUM_SIMD*ADDR_WIDTH-1:0] SIMD_g_arg_pointer,
  output logic [NUM_SIMD*ADDR_WIDTH-1:0] SIMD_l_arg_pointer,
  output logic [NUM_SIMD-1:0]            SIMD_reset,
  input  logic [NUM_SIMD-1:0]            SIMD_done,
  input  logic                           SN_next_op,
  input  logic [ADDR_WIDTH-1:0]          SN_next_addr,
  input  logic [WL_LEN_BITS-1:0]         SN_next_len,
  output logic                           SN_clr_next,
  output logic                           SN_req_done
);

  // state      | meaning
  // IDLE       | waiting for a work list from the signal network
  // ACK        | SN_clr_next pulse; empty list goes straight to DONE
  // FETCH_REQ  | descriptor read request held until MRA_ready
  // FETCH_WAIT | waiting for the descriptor line
  // PF_WAIT    | PF core running on the current entry
  // DISPATCH   | waiting for an idle channel, then loading it
  // DRAIN      | all entries dispatched, waiting for every channel to go idle
  // DONE       | SN_req_done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_FETCH_REQ, S_FETCH_WAIT, S_PF_WAIT, S_DISPATCH, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0]  LINE_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [WL_LEN_BITS-1:0] IDX_ONE    = WL_LEN_BITS'(1);

  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WL_LEN_BITS-1:0]  len_q;
  logic [WL_LEN_BITS-1:0]  idx_q;
  logic [ADDR_WIDTH-1:0]   pf_q;
  logic [ADDR_WIDTH-1:0]   simd_q;
  logic [ADDR_WIDTH-1:0]   garg_q;
  logic [ADDR_WIDTH-1:0]   larg_q;
  logic [NUM_SIMD-1:0]     busy_q;
  logic [ADDR_WIDTH-1:0]   ch_ptr  [NUM_SIMD];
  logic [ADDR_WIDTH-1:0]   ch_garg [NUM_SIMD];
  logic [ADDR_WIDTH-1:0]   ch_larg [NUM_SIMD];

  logic [NUM_SIMD-1:0]     sel_oh;
  logic                    any_idle;
  logic                    dispatch_fire;
  logic                    last_entry;
  logic                    pf_skip;
  logic                    unused_rsp_bits;

  assign unused_rsp_bits = ^MRA_rsp_data;

`ifdef TC_FSM_MC_PF_BYPASS_EN
  assign pf_skip = (MRA_rsp_data[ADDR_WIDTH-1:0] == '0);
`else
  assign pf_skip = 1'b0;
`endif

  // Lowest-index idle channel; a done pulse only frees a channel from the next cycle on.
  always_comb begin
    sel_oh   = '0;
    any_idle = 1'b0;
    for (int i = 0; i < NUM_SIMD; i++) begin
      if (!busy_q[i] && !any_idle) begin
        sel_oh[i] = 1'b1;
        any_idle  = 1'b1;
      end
    end
  end

  assign dispatch_fire = (state == S_DISPATCH) && any_idle;
  assign last_entry    = ((idx_q + IDX_ONE) == len_q);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:       if (SN_next_op) state_d = S_ACK;
      S_ACK:        state_d = (len_q == '0) ? S_DONE : S_FETCH_REQ;
      S_FETCH_REQ:  if (MRA_ready) state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: if (MRA_rsp_valid) state_d = pf_skip ? S_DISPATCH : S_PF_WAIT;
      S_PF_WAIT:    if (PF_done) state_d = S_DISPATCH;
      S_DISPATCH:   if (any_idle) state_d = last_entry ? S_DRAIN : S_FETCH_REQ;
      S_DRAIN:      if (busy_q == '0) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      addr_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      pf_q   <= '0;
      simd_q <= '0;
      garg_q <= '0;
      larg_q <= '0;
      busy_q <= '0;
      for (int i = 0; i < NUM_SIMD; i++) begin
        ch_ptr[i]  <= '0;
        ch_garg[i] <= '0;
        ch_larg[i] <= '0;
      end
    end else begin
      state <= state_d;
      if (state == S_IDLE && SN_next_op) begin
        addr_q <= SN_next_addr;
        len_q  <= SN_next_len;
        idx_q  <= '0;
      end
      if (state == S_FETCH_WAIT && MRA_rsp_valid) begin
        pf_q   <= MRA_rsp_data[ADDR_WIDTH-1:0];
        simd_q <= MRA_rsp_data[2*ADDR_WIDTH-1:ADDR_WIDTH];
        garg_q <= MRA_rsp_data[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
        larg_q <= MRA_rsp_data[4*ADDR_WIDTH-1:3*ADDR_WIDTH];
      end
      if (dispatch_fire) begin
        idx_q  <= idx_q + IDX_ONE;
        addr_q <= addr_q + LINE_BYTES;
      end
      busy_q <= (busy_q & ~SIMD_done) | (dispatch_fire ? sel_oh : '0);
      for (int i = 0; i < NUM_SIMD; i++) begin
        if (dispatch_fire && sel_oh[i]) begin
          ch_ptr[i]  <= simd_q;
          ch_garg[i] <= garg_q;
          ch_larg[i] <= larg_q;
        end
      end
    end
  end

  assign MRA_req_addr  = addr_q;
  assign MRA_rw        = 1'b0;
  assign MRA_req_valid = (state == S_FETCH_REQ);
  assign PF_pointer    = pf_q;
  assign PF_reset      = (state != S_PF_WAIT);
  assign SN_clr_next   = (state == S_ACK);
  assign SN_req_done   = (state == S_DONE);
  assign SIMD_reset    = ~busy_q;

  for (genvar g = 0; g < NUM_SIMD; g++) begin : g_ch_out
    assign SIMD_pointer[g*ADDR_WIDTH +: ADDR_WIDTH]       = ch_ptr[g];
    assign SIMD_g_arg_pointer[g*ADDR_WIDTH +: ADDR_WIDTH] = ch_garg[g];
    assign SIMD_l_arg_pointer[g*ADDR_WIDTH +: ADDR_WIDTH] = ch_larg[g];
  end

endmodule
